// File: rtl/spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares a single spi_master_driver (CPOL=0, CPHA=1) between N_REQ requesters
// using round-robin arbitration. For each granted requester the arbiter issues
// a one-cycle start pulse, waits for the driver to go busy and then idle again,
// captures the received word and pulses done for the owner. A watchdog ends a
// transfer that the driver never accepts (ready never falls) and reports it on
// err together with done.
//
// Parameters:
//   DATA_WIDTH   - SPI word width, must match the driver.
//   N_REQ        - number of requesters, 2..8.
//   BUSY_TIMEOUT - cycles to wait for m_ready to fall after the start pulse,
//                  2..255.
//
// Ports:
//   clk        in   system clock, rising edge.
//   rst        in   asynchronous active-high reset.
//   req        in   [N_REQ]            per-requester request level.
//   wdata      in   [N_REQ*DATA_WIDTH] write words, requester i at
//                                      [i*DATA_WIDTH +: DATA_WIDTH].
//   grant      out  [N_REQ]            one-hot owner of the current transfer.
//   done       out  [N_REQ]            one-cycle completion pulse for owner.
//   rdata      out  [DATA_WIDTH]       word from the last completed transfer.
//   err        out                     pulses with done when the transfer
//                                      timed out.
//   m_start    out                     driver start_transaction.
//   m_data_in  out  [DATA_WIDTH]       driver data_in.
//   m_data_out in   [DATA_WIDTH]       driver data_out.
//   m_ready    in                      driver ready.
// -----------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int N_REQ        = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        err,
    output logic                        m_start,
    output logic [DATA_WIDTH-1:0]       m_data_in,
    input  logic [DATA_WIDTH-1:0]       m_data_out,
    input  logic                        m_ready
);

    localparam int              IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(N_REQ - 1);
    localparam logic [7:0]      TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       rr;
    logic [IDX_W-1:0]       rr_nxt;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nxt;
    logic                   tmo;
    logic                   tmo_nxt;
    logic [N_REQ-1:0]       grant_nxt;
    logic                   m_start_nxt;
    logic [DATA_WIDTH-1:0]  m_data_in_nxt;
    logic [DATA_WIDTH-1:0]  rdata_nxt;

    logic [IDX_W-1:0]       win;
    logic [N_REQ-1:0]       win_onehot;
    logic [DATA_WIDTH-1:0]  win_data;

    // Round-robin search starting just after the last owner. The loop runs
    // from the farthest candidate to the nearest so the nearest set request
    // is the one left in pick.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] pick;
        logic [N_REQ-1:0] sh;
        int               idx;
        pick = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            sh  = r >> idx;
            if (sh[0]) begin
                pick = IDX_W'(idx);
            end
        end
        return pick;
    endfunction

    // Winner decode: one-hot grant vector and the winner's write word.
    always_comb begin
        win        = rr_pick(req, rr);
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == win) begin
                win_onehot[i] = 1'b1;
                win_data      = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr;
        cnt_nxt       = cnt;
        tmo_nxt       = tmo;
        grant_nxt     = grant;
        m_start_nxt   = 1'b0;
        m_data_in_nxt = m_data_in;
        rdata_nxt     = rdata;

        case (state)
            IDLE: begin
                // A busy (or resetting) driver blocks granting entirely.
                if (m_ready && (|req)) begin
                    grant_nxt     = win_onehot;
                    m_data_in_nxt = win_data;
                    m_start_nxt   = 1'b1;
                    rr_nxt        = win;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                tmo_nxt   = 1'b0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!m_ready) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == TMO_LAST) begin
                    // Driver never took the word; finish with err, rdata kept.
                    tmo_nxt   = 1'b1;
                    state_nxt = COMPLETE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            WAIT_DONE: begin
                // Capture on the way into COMPLETE so rdata is already valid
                // in the done cycle.
                if (m_ready) begin
                    rdata_nxt = m_data_out;
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // done and err are decoded from the registered state, so they can only
    // be high during COMPLETE.
    always_comb begin
        done = '0;
        err  = 1'b0;
        if (state == COMPLETE) begin
            done = grant;
            err  = tmo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= RR_RESET;
            cnt       <= '0;
            tmo       <= 1'b0;
            grant     <= '0;
            m_start   <= 1'b0;
            m_data_in <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            rr        <= rr_nxt;
            cnt       <= cnt_nxt;
            tmo       <= tmo_nxt;
            grant     <= grant_nxt;
            m_start   <= m_start_nxt;
            m_data_in <= m_data_in_nxt;
            rdata     <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Bench for spi_master_arbiter. Contains a behavioural SPI driver + slave
// (CPOL=0, CPHA=1, MSB first, two clocks per bit) and a transaction-level
// reference model of the arbiter: round-robin choice, grant/data hold, done
// latency, timeout and rdata bookkeeping.
// -----------------------------------------------------------------------------
module tb_spi_master_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int BT = 16;
    localparam int WW = N * DW;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [WW-1:0] wdata;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          m_start;
    logic [DW-1:0] m_data_in;
    logic [DW-1:0] m_data_out;
    logic          m_ready;

    spi_master_arbiter #(
        .DATA_WIDTH  (DW),
        .N_REQ       (N),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wdata     (wdata),
        .grant     (grant),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .m_start   (m_start),
        .m_data_in (m_data_in),
        .m_data_out(m_data_out),
        .m_ready   (m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- behavioural driver + slave ----------------
    logic          drv_ready;
    logic          hold_busy;
    logic          stuck;
    logic          rand_reply;
    logic [DW-1:0] fixed_reply;
    logic          sclk, mosi, miso;
    logic [DW-1:0] last_rx;
    logic [DW-1:0] last_reply;

    assign m_ready = drv_ready && !hold_busy;

    initial begin : driver
        logic [DW-1:0] word, reply, rx_s, rx_m;
        logic          aborted;
        drv_ready  = 1'b1;
        m_data_out = '0;
        sclk = 1'b0; mosi = 1'b0; miso = 1'b0;
        last_rx = '0; last_reply = '0;
        forever begin
            @(negedge clk);
            if (!rst && !stuck && m_start && m_ready) begin
                word    = m_data_in;
                reply   = rand_reply ? DW'($urandom) : fixed_reply;
                aborted = 1'b0;
                rx_s    = '0;
                rx_m    = '0;
                @(posedge clk); #2;
                if (rst) aborted = 1'b1;
                else drv_ready = 1'b0;
                for (int b = DW - 1; b >= 0 && !aborted; b--) begin
                    @(posedge clk); #2;
                    if (rst) aborted = 1'b1;
                    else begin
                        sclk = 1'b1; mosi = word[b]; miso = reply[b];
                    end
                    if (!aborted) begin
                        @(posedge clk); #2;
                        if (rst) aborted = 1'b1;
                        else begin
                            sclk = 1'b0;
                            rx_s = {rx_s[DW-2:0], mosi};
                            rx_m = {rx_m[DW-2:0], miso};
                        end
                    end
                end
                if (!aborted) begin
                    last_rx    = rx_s;
                    last_reply = reply;
                    m_data_out = rx_m;
                end
                sclk      = 1'b0;
                drv_ready = 1'b1;
            end
        end
    end

    // ---------------- reference model / monitor ----------------
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    int            cyc = 0;
    logic          m_idle = 1'b1;
    logic          idle_in_prev = 1'b1;
    logic          gate_s = 1'b0;
    logic [N-1:0]  req_s = '0;
    logic [WW-1:0] wdata_s = '0;
    int            rr_m = N - 1;
    int            cur_w, start_cyc, lat, exp_lat;
    logic [DW-1:0] cur_word;
    logic          cur_stuck;
    logic [DW-1:0] rdata_exp = '0;
    logic          exp_start, idle_before, is_done;
    logic          last_err = 1'b0;
    logic [N-1:0]  last_done = '0;
    int            n_starts = 0;
    int            n_dones = 0;
    logic [DW-1:0] start_log[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_idle = 1'b1; idle_in_prev = 1'b1; gate_s = 1'b0;
            rr_m = N - 1; rdata_exp = '0;
        end else begin
            idle_before = m_idle;
            exp_start   = idle_in_prev && gate_s && (req_s != '0);
            chk("m_start", 32'(m_start), 32'(exp_start));
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (exp_start) begin
                cur_w    = pick(req_s, rr_m);
                cur_word = DW'(wdata_s >> (cur_w * DW));
                chk("grant_at_start", 32'(grant), 32'(1) << cur_w);
                chk("data_at_start", 32'(m_data_in), 32'(cur_word));
                chk("done_at_start", 32'(done), 32'd0);
                rr_m = cur_w; start_cyc = cyc; cur_stuck = stuck;
                m_idle = 1'b0; n_starts++;
                start_log.push_back(m_data_in);
            end else if (!m_idle) begin
                lat     = cyc - start_cyc;
                exp_lat = cur_stuck ? BT + 1 : 2 * DW + 2;
                is_done = (lat == exp_lat);
                chk("grant_hold", 32'(grant), 32'(1) << cur_w);
                chk("data_hold", 32'(m_data_in), 32'(cur_word));
                chk("done", 32'(done), is_done ? (32'(1) << cur_w) : 32'd0);
                chk("err", 32'(err), 32'(is_done && cur_stuck));
                if (is_done) begin
                    if (!cur_stuck) begin
                        chk("slave_rx", 32'(last_rx), 32'(cur_word));
                        rdata_exp = last_reply;
                    end
                    last_err  = cur_stuck;
                    last_done = done;
                    n_dones++;
                end
                if (lat >= exp_lat) m_idle = 1'b1;
            end else begin
                chk("grant_idle", 32'(grant), 32'd0);
                chk("done_idle", 32'(done), 32'd0);
                chk("err_idle", 32'(err), 32'd0);
            end
            chk("rdata", 32'(rdata), 32'(rdata_exp));
            idle_in_prev = idle_before && !exp_start;
            gate_s       = m_ready;
        end
        req_s   = req;
        wdata_s = wdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_starts(input int k);
        int target;
        target = n_starts + k;
        for (int i = 0; i < 400 && n_starts < target; i++) step();
        chk("start_wait", 32'(n_starts >= target), 32'd1);
    endtask

    task automatic wait_dones(input int k);
        int target;
        target = n_dones + k;
        for (int i = 0; i < 600 && n_dones < target; i++) step();
        chk("done_wait", 32'(n_dones >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_data_in", 32'(m_data_in), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    logic [DW-1:0] exp_seq[4];
    logic [DW-1:0] keep;
    int            d0, s0;

    initial begin
        rst = 1'b1; req = '0; wdata = '0;
        hold_busy = 1'b0; stuck = 1'b0;
        rand_reply = 1'b0; fixed_reply = 8'h3C;
        step(); step();
        chk("init_grant", 32'(grant), 32'd0);
        chk("init_m_start", 32'(m_start), 32'd0);
        chk("init_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;

        // single requester 0: A5 out, 3C back
        wdata = {8'h00, 8'hA5};
        req = 2'b01;
        wait_starts(1);
        req = '0;
        wait_dones(1);
        chk("t1_rdata", 32'(rdata), 32'h3C);
        chk("t1_mosi", 32'(last_rx), 32'hA5);
        chk("t1_err", 32'(last_err), 32'd0);
        chk("t1_done", 32'(last_done), 32'b01);

        // both held: alternating service
        do_reset();
        rand_reply = 1'b1;
        wdata = {8'h22, 8'h11};
        start_log.delete();
        req = 2'b11;
        wait_dones(4);
        req = '0;
        exp_seq = '{8'h11, 8'h22, 8'h11, 8'h22};
        chk("t2_count", 32'(start_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < start_log.size()) chk("t2_seq", 32'(start_log[i]), 32'(exp_seq[i]));
        end

        // one-cycle request from requester 1
        req = 2'b10;
        step();
        req = '0;
        wait_dones(1);
        chk("t3_done", 32'(last_done), 32'b10);
        req = 2'b11;
        wait_starts(1);
        chk("t3_next_grant", 32'(grant), 32'b01);
        req = '0;
        wait_dones(1);

        // stuck driver: watchdog
        stuck = 1'b1;
        keep = rdata;
        req = 2'b01;
        wait_starts(1);
        req = '0;
        wait_dones(1);
        chk("t4_err", 32'(last_err), 32'd1);
        chk("t4_rdata_kept", 32'(rdata), 32'(keep));
        stuck = 1'b0;
        req = 2'b10;
        wait_starts(1);
        req = '0;
        wait_dones(1);
        chk("t4_recover_err", 32'(last_err), 32'd0);

        // reset while in WAIT_DONE
        req = 2'b01;
        wait_starts(1);
        req = '0;
        repeat (5) step();
        d0 = n_dones;
        do_reset();
        repeat (4) step();
        chk("t5_no_done", 32'(n_dones), 32'(d0));
        rand_reply = 1'b0; fixed_reply = 8'h5A;
        wdata = {8'h00, 8'h77};
        req = 2'b01;
        wait_starts(1);
        req = '0;
        wait_dones(1);
        chk("t5_rdata", 32'(rdata), 32'h5A);
        chk("t5_mosi", 32'(last_rx), 32'h77);

        // wdata changed mid-transfer
        wdata = {8'h00, 8'hF0};
        start_log.delete();
        req = 2'b01;
        wait_starts(1);
        req = '0;
        wdata = {8'h00, 8'h0F};
        wait_dones(1);
        chk("t6_mosi", 32'(last_rx), 32'hF0);
        chk("t6_m_data_in", 32'(m_data_in), 32'hF0);

        // driver busy in IDLE blocks granting
        s0 = n_starts;
        hold_busy = 1'b1;
        req = 2'b11;
        repeat (6) step();
        chk("t7_blocked", 32'(n_starts), 32'(s0));
        hold_busy = 1'b0;
        wait_starts(1);
        req = '0;
        wait_dones(1);

        // randomized traffic
        rand_reply = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) req = '0;
            else req = N'($urandom);
            wdata = WW'($urandom);
            step();
        end
        req = '0;
        repeat (4 * DW + BT + 10) step();
        chk("final_idle", 32'(m_idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one `spi_master_driver` instance (CPOL=0, CPHA=1) between N_REQ requesters using round-robin arbitration.
- Sequences each word transfer: start pulse, busy detection, completion, read-data capture.
- Sits between functional units (e.g. multiplier I/O, host link) and the single SPI master.
- Adds a watchdog that flags a transfer the driver never accepts.

Parameters:
- DATA_WIDTH, 8: SPI word width; must match the driven `spi_master_driver`.
- N_REQ, 2: number of requesters, legal range 2..8.
- BUSY_TIMEOUT, 16: max cycles to wait for `m_ready` to fall after the start pulse; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester transfer request, level.
- wdata  in  N_REQ*DATA_WIDTH  per-requester write words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  out  N_REQ  one-hot, registered; high for the owner of the current transfer.
- done  out  N_REQ  one-hot, one-cycle pulse; transfer finished for that requester.
- rdata  out  DATA_WIDTH  word received in the last completed transfer; valid from the done cycle until the next done.
- err  out  1  one-cycle pulse with done: the last transfer timed out.
- m_start  out  1  to driver `start_transaction`.
- m_data_in  out  DATA_WIDTH  to driver `data_in`.
- m_data_out  in  DATA_WIDTH  from driver `data_out`.
- m_ready  in  1  from driver `ready`.

Behaviour:
- Reset values:
  - grant=0, done=0, err=0, m_start=0, m_data_in=0, rdata=0.
  - state=IDLE, timeout counter=0.
  - rr pointer=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE:
  - Leaves only when m_ready=1 and req!=0.
  - Winner = first set req bit searching from rr+1 upward, wrapping at N_REQ.
  - Next edge: grant[winner]<=1, m_data_in<=wdata[winner], m_start<=1, rr<=winner, go to ISSUE.
  - Latency: req high at edge k means m_start is high during cycle k+1.
- ISSUE:
  - m_start is high for exactly this one cycle; cleared on exit.
  - Counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - If m_ready=0, go to WAIT_DONE.
  - Else increment counter; when counter reaches BUSY_TIMEOUT-1, go to COMPLETE with err flag set.
- WAIT_DONE:
  - On m_ready=1, go to COMPLETE.
  - No timeout in this state; transfer length is governed by the driver.
- COMPLETE (one cycle):
  - done[winner]=1; rdata<=m_data_out, or held unchanged on timeout; err=flag.
  - grant cleared at the end of this cycle; go to IDLE.
  - IDLE may grant again on the following edge, so the minimum gap between m_start pulses is 4 cycles plus the transfer length.
- m_data_in is held constant from ISSUE through COMPLETE; wdata changes after grant are ignored.
- Dropping req after grant does not abort the transfer; done still pulses.
- A requester that holds req continuously yields to other pending requesters via round robin; with a single requester it is re-granted back-to-back.
- m_ready=0 in IDLE (driver still busy or in reset) blocks granting; no m_start is issued.
- Reset asserted mid-transfer: all outputs return to reset values immediately (async). No done pulse; the in-flight word is lost. The driver is reset by the same rst.
- grant is one-hot or zero at all times. done and err are never high outside COMPLETE.

Test Plan:
- Single req[0], wdata0=0xA5, slave model returns 0x3C → one m_start pulse one cycle after req; grant=01; done=01 once; rdata=0x3C; err=0; mosi bit stream 10100101 MSB first.
- req=11 held, wdata0=0x11, wdata1=0x22, after reset → m_data_in sequence 0x11, 0x22, 0x11, 0x22; done alternates 01, 10; never two grants at once.
- req[1] asserted for 1 cycle, then dropped → transfer completes; done=10 pulses; rr advances to 1.
- m_ready tied high (driver stuck) → after BUSY_TIMEOUT=16 cycles in WAIT_BUSY, done and err pulse together; rdata unchanged; arbiter returns to IDLE and serves the next request.
- rst pulsed while WAIT_DONE → grant=0, m_start=0, no done; the next req[0] completes normally with the correct rdata.
- wdata0 changed from 0xF0 to 0x0F during a transfer → m_data_in stays 0xF0 and the slave receives 0xF0.
